// File: rtl/mux_arb_n_if.sv
// Handshake bundle for mux_arb_n: N packed producer lanes plus one consumer port.
interface mux_arb_n_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned NUM_IN     = 4,
  parameter int unsigned SEL_WIDTH  = $clog2(NUM_IN)
);
  logic [NUM_IN*DATA_WIDTH-1:0] in_data;
  logic [NUM_IN-1:0]            in_valid;
  logic [NUM_IN-1:0]            in_ready;
  logic [SEL_WIDTH-1:0]         sel;
  logic [DATA_WIDTH-1:0]        out_data;
  logic                         out_valid;
  logic                         out_ready;
  logic [SEL_WIDTH-1:0]         out_src;

  modport master (
    output in_data, in_valid, sel, out_ready,
    input  in_ready, out_data, out_valid, out_src
  );

  modport slave (
    input  in_data, in_valid, sel, out_ready,
    output in_ready, out_data, out_valid, out_src
  );
endinterface

// File: rtl/mux_arb_n.sv
// N-input registered select stage: explicit select (MODE 0) or round-robin (MODE 1),
// with one output register that can refill in the same cycle it drains.
module mux_arb_n #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned NUM_IN     = 4,
  parameter int unsigned SEL_WIDTH  = $clog2(NUM_IN),
  parameter int unsigned MODE       = 0
) (
  input logic        CLK,
  input logic        RST,
  mux_arb_n_if.slave bus
);

  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic [SEL_WIDTH-1:0]  out_src_q, out_src_d;
  logic                  out_valid_q, out_valid_d;
  logic [SEL_WIDTH-1:0]  ptr_q, ptr_d;

  logic                  can_load_c;
  logic                  any_grant_c;
  logic                  xfer_c;
  logic [SEL_WIDTH-1:0]  winner_c;
  logic [NUM_IN-1:0]     in_ready_c;
  logic [DATA_WIDTH-1:0] data_sel_c;
  int unsigned           idx_c;

  // Grant: selected lane if valid, or first valid lane after ptr with wrap-around.
  always_comb begin
    winner_c    = '0;
    any_grant_c = 1'b0;
    idx_c       = 0;
    if (MODE == 0) begin
      winner_c = bus.sel;
      for (int unsigned i = 0; i < NUM_IN; i++) begin
        if (bus.sel == SEL_WIDTH'(i)) any_grant_c = bus.in_valid[i];
      end
    end else begin
      for (int unsigned k = 1; k <= NUM_IN; k++) begin
        idx_c = 32'(ptr_q) + k;
        if (idx_c >= NUM_IN) idx_c = idx_c - NUM_IN;
        for (int unsigned i = 0; i < NUM_IN; i++) begin
          if (!any_grant_c && (idx_c == i) && bus.in_valid[i]) begin
            any_grant_c = 1'b1;
            winner_c    = SEL_WIDTH'(i);
          end
        end
      end
    end
  end

  // Ready is suppressed while reset is held so nothing is consumed in that cycle.
  always_comb begin
    can_load_c = !out_valid_q || bus.out_ready;
    xfer_c     = can_load_c && any_grant_c && RST;
    in_ready_c = '0;
    data_sel_c = '0;
    for (int unsigned i = 0; i < NUM_IN; i++) begin
      if (winner_c == SEL_WIDTH'(i)) begin
        in_ready_c[i] = xfer_c;
        data_sel_c    = bus.in_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Next state of the output register and arbitration pointer.
  always_comb begin
    out_data_d  = out_data_q;
    out_src_d   = out_src_q;
    out_valid_d = out_valid_q;
    ptr_d       = ptr_q;
    if (xfer_c) begin
      out_data_d  = data_sel_c;
      out_src_d   = winner_c;
      out_valid_d = 1'b1;
      ptr_d       = winner_c;
    end else if (out_valid_q && bus.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // ptr resets to the last lane so lane 0 is searched first.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      out_data_q  <= '0;
      out_src_q   <= '0;
      out_valid_q <= 1'b0;
      ptr_q       <= SEL_WIDTH'(NUM_IN - 1);
    end else begin
      out_data_q  <= out_data_d;
      out_src_q   <= out_src_d;
      out_valid_q <= out_valid_d;
      ptr_q       <= ptr_d;
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_data  = out_data_q;
  assign bus.out_src   = out_src_q;
  assign bus.out_valid = out_valid_q;

endmodule
